prog_loader: RTL

//   Writer side of the program-memory interface that the control unit reads from.

---
 rtl/prog_loader_if.sv | 27 ++
 rtl/prog_loader.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/prog_loader_if.sv
// Byte-in / word-out bus of the program loader: UART receive strobe and program-memory write port.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 16
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [ADDR_W-1:0] pm_addr;
  logic [DATA_W-1:0] pm_data;
  logic              pm_we;

  modport master (
    input  rx_data,
    input  rx_valid,
    output pm_addr,
    output pm_data,
    output pm_we
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  pm_addr,
    input  pm_data,
    input  pm_we
  );
endinterface

// File: rtl/prog_loader.sv
// Packs UART bytes into 16-bit instruction words, writes them to program memory and
// holds the CPU in reset until a HLT word (or MAX_WORDS). LOADER_CHECKSUM_EN adds an XOR check byte.
module prog_loader #(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_WORDS = 2048
) (
  input  logic              clk,
  input  logic              reset,
  prog_loader_if.master     bus,
  output logic              cpu_reset,
  output logic              done,
  output logic              overflow,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WORDS - 1);

  typedef enum logic [2:0] {
    LOAD_HI,
    LOAD_LO,
`ifdef LOADER_CHECKSUM_EN
    CHECK,
    ERROR,
`endif
    FINISH,
    RUN
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] pm_addr_q, pm_addr_d;
  logic [DATA_W-1:0] pm_data_q, pm_data_d;
  logic              pm_we_q, pm_we_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  words_q, words_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic              err_q, err_d;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    pm_addr_d   = pm_addr_q;
    pm_data_d   = pm_data_q;
    pm_we_d     = 1'b0;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    overflow_d  = overflow_q;
    words_d     = words_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d      = csum_q;
    err_d       = err_q;
`endif

    unique case (state_q)
      LOAD_HI: begin
        if (bus.rx_valid) begin
          hi_d    = bus.rx_data;
          state_d = LOAD_LO;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ bus.rx_data;
`endif
        end
      end
      LOAD_LO: begin
        if (bus.rx_valid) begin
          pm_we_d   = 1'b1;
          pm_data_d = DATA_W'({hi_q, bus.rx_data});
          pm_addr_d = words_q[ADDR_W-1:0];
          words_d   = words_q + CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
          csum_d    = csum_q ^ bus.rx_data;
`endif
          // HLT wins over the word-count limit when both apply
          if (hi_q[7:3] == 5'b00000) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = FINISH;
`endif
          end else if (words_q == LAST_CNT) begin
            state_d    = FINISH;
            overflow_d = 1'b1;
          end else begin
            state_d = LOAD_HI;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == csum_q) begin
            state_d = FINISH;
          end else begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
        end
      end
      ERROR: ;
`endif
      FINISH: begin
        cpu_reset_d = 1'b0;
        done_d      = 1'b1;
        state_d     = RUN;
      end
      RUN: ;
      default: state_d = LOAD_HI;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD_HI;
      hi_q        <= '0;
      pm_addr_q   <= '0;
      pm_data_q   <= '0;
      pm_we_q     <= 1'b0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      words_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      pm_addr_q   <= pm_addr_d;
      pm_data_q   <= pm_data_d;
      pm_we_q     <= pm_we_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      words_q     <= words_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
      err_q       <= err_d;
`endif
    end
  end

  assign bus.pm_addr   = pm_addr_q;
  assign bus.pm_data   = pm_data_q;
  assign bus.pm_we     = pm_we_q;
  assign cpu_reset     = cpu_reset_q;
  assign done          = done_q;
  assign overflow      = overflow_q;
  assign words_loaded  = words_q;
`ifdef LOADER_CHECKSUM_EN
  assign err           = err_q;
`else
  assign err           = 1'b0;
`endif

endmodule
